jenkins_feeder: RTL
===================

// Module: jenkins_feeder
// PURPOSE
//  Upstream stage of the Jenkins hash core. Accepts a whole string (up to MAX_LEN bytes) over a
//  valid/ready handshake and serialises it as the core's sample/value byte stream. Waits for the
//  core's complete pulse, then holds the 32-bit hash until the consumer takes it.
//  Turns the core's raw sample/complete stream into a transaction-level request/response interface.
// PARAMETERS
//  MAX_LEN   16  maximum string length in bytes
//  LW        $clog2(MAX_LEN+1)  length field width (derived, not overridable)
// PORTS
//  clock          in   1          rising-edge clock
//  resetn         in   1          asynchronous active-low reset
//  in_valid       in   1          request valid
//  in_ready       out  1          feeder idle; request accepted when in_valid && in_ready
//  in_len         in   LW         string length in bytes
//  in_data        in   8*MAX_LEN  string; byte 0 = in_data[7:0] is sent first
//  sample         out  1          byte strobe to the hash core
//  value          out  8          byte to the hash core, valid while sample=1
//  hash_complete  in   1          core finished; hash_in is valid this cycle
//  hash_in        in   32         hash from the core
//  out_valid      out  1          result valid
//  out_ready      in   1          consumer takes the result when out_valid && out_ready
//  out_hash       out  32         captured hash
//  out_err        out  1          charset violation in this string (macro only; else 0)
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, in_ready=1, sample=0, value=0, out_valid=0,
//   out_hash=0, out_err=0. Reset mid-operation abandons the string; no result is produced.
//  FSM IDLE -> STREAM -> WAIT -> RESULT -> IDLE:
//   IDLE: in_ready=1. On accept, latch in_data and len=min(in_len,MAX_LEN).
//     If len=0, go directly to RESULT with out_hash=0 (Jenkins hash of the empty string).
//     Otherwise go to STREAM.
//   STREAM: one byte per cycle, sample=1, value=byte[idx], idx 0..len-1, no gaps.
//     Exits to WAIT after byte len-1. Bytes within a string are contiguous.
//   WAIT: sample=0. On hash_complete, latch out_hash<=hash_in and go to RESULT.
//     hash_complete seen in IDLE, STREAM or RESULT is ignored.
//   RESULT: out_valid=1 and out_hash is held stable until out_ready.
//     On the handshake, go to IDLE. A new request is accepted no earlier than the next cycle.
//  Latency: request accept -> first sample = 1 cycle. sample is low for >=2 cycles between
//   strings (the low edge terminates the message at the core).
//  Backpressure: out_ready=0 stalls indefinitely in RESULT; in_ready stays 0 meanwhile.
//  in_len > MAX_LEN is clamped to MAX_LEN silently. The index counter never wraps.
//  Registered outputs only; no combinational path from in_* or out_ready to outputs,
//   except in_ready, which is decoded from state.
// CONFIGURATION
//  JENKINS_FEEDER_CHARSET_CHECK_EN defined:
//   - Each streamed byte is checked against [a-z], [A-Z], [0-9].
//   - Any miss sets a sticky per-string flag, cleared on request accept.
//   - The flag is presented as out_err with the result.
//   - The byte is still sent; the string is not aborted.
//  Macro undefined: out_err is tied to 0 and no checker logic is built.
// STRUCTURE
//  Package jencoll_pkg holds:
//   - the state enum (IDLE, STREAM, WAIT, RESULT)
//   - HASH_W=32 and BYTE_W=8
//   - function is_alnum(byte)
//  No sub-module; byte selection is an indexed part-select of the latched string register.
// TESTING
//  1. "a", len=1 -> one sample cycle, value=8'h61; core model returns 32'hca2e9442;
//     out_valid with out_hash=32'hca2e9442 and out_err=0.
//  2. len=0 -> no sample pulse; out_valid 1 cycle after accept, out_hash=0.
//  3. "abc", len=3, out_ready held 0 for 10 cycles -> sample high for exactly 3 cycles
//     (61,62,63); out_hash stable throughout; in_ready=0 until the handshake.
//  4. in_len=20 with MAX_LEN=16 -> exactly 16 sample cycles; bytes 16..19 never emitted.
//  5. resetn pulled low during STREAM byte 2 of 5 -> sample=0 immediately, out_valid never
//     asserts, in_ready=1 after release.
//  6. (macro defined) "a_b" -> 3 bytes emitted, out_err=1. The next string "ab" gives out_err=0.

Source files
------------

// File: rtl/jenkins_feeder_pkg.sv
// Shared types and helpers for the Jenkins hash feeder.
package jencoll_pkg;

  localparam int unsigned HASH_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  // True for [a-z], [A-Z], [0-9]
  function automatic logic is_alnum(input logic [BYTE_W-1:0] b);
    return ((b >= 8'h61) && (b <= 8'h7a)) ||
           ((b >= 8'h41) && (b <= 8'h5a)) ||
           ((b >= 8'h30) && (b <= 8'h39));
  endfunction

endpackage

// File: rtl/jenkins_feeder_if.sv
// Request/response transaction interface of the Jenkins hash feeder.
interface jenkins_feeder_if
  import jencoll_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [LW-1:0]             in_len;
  logic [BYTE_W*MAX_LEN-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [HASH_W-1:0]         out_hash;
  logic                      out_err;

  modport master (
    output in_valid, in_len, in_data, out_ready,
    input  in_ready, out_valid, out_hash, out_err
  );

  modport slave (
    input  in_valid, in_len, in_data, out_ready,
    output in_ready, out_valid, out_hash, out_err
  );

endinterface

// File: rtl/jenkins_feeder.sv
// Jenkins hash feeder: serialises a whole string into the core's sample/value
// byte stream, waits for the core's complete pulse and holds the hash until taken.
// Optional charset checker enabled by defining JENKINS_FEEDER_CHARSET_CHECK_EN.
module jenkins_feeder
  import jencoll_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic              clock,
  input  logic              resetn,
  jenkins_feeder_if.slave   bus,
  output logic              sample,
  output logic [BYTE_W-1:0] value,
  input  logic              hash_complete,
  input  logic [HASH_W-1:0] hash_in
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned DW = BYTE_W * MAX_LEN;

  state_t            state_q, state_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DW-1:0]     data_q, data_d;
  logic              sample_q, sample_d;
  logic [BYTE_W-1:0] value_q, value_d;
  logic              out_valid_q, out_valid_d;
  logic [HASH_W-1:0] out_hash_q, out_hash_d;
  logic [LW-1:0]     len_clamp;

`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
  logic err_q, err_d;
  logic out_err_q, out_err_d;
`endif

  // Oversized requests are silently clamped to the string register size
  assign len_clamp = (bus.in_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.in_len;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    data_d      = data_q;
    sample_d    = 1'b0;
    value_d     = '0;
    out_valid_d = out_valid_q;
    out_hash_d  = out_hash_q;
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
    err_d       = err_q;
    out_err_d   = out_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d = bus.in_data;
          len_d  = len_clamp;
          if (len_clamp == '0) begin
            state_d     = RESULT;
            out_valid_d = 1'b1;
            out_hash_d  = '0;
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
            err_d       = 1'b0;
            out_err_d   = 1'b0;
`endif
          end else begin
            // Byte 0 goes out on the cycle right after accept
            state_d  = STREAM;
            sample_d = 1'b1;
            value_d  = bus.in_data[BYTE_W-1:0];
            idx_d    = LW'(1);
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
            err_d    = ~is_alnum(bus.in_data[BYTE_W-1:0]);
`endif
          end
        end
      end
      STREAM: begin
        if (idx_q == len_q) begin
          state_d = WAIT;
        end else begin
          sample_d = 1'b1;
          value_d  = data_q[{idx_q, 3'b000} +: BYTE_W];
          idx_d    = idx_q + LW'(1);
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
          err_d    = err_q | ~is_alnum(data_q[{idx_q, 3'b000} +: BYTE_W]);
`endif
        end
      end
      WAIT: begin
        if (hash_complete) begin
          state_d     = RESULT;
          out_valid_d = 1'b1;
          out_hash_d  = hash_in;
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
          out_err_d   = err_q;
`endif
        end
      end
      RESULT: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      sample_q    <= 1'b0;
      value_q     <= '0;
      out_valid_q <= 1'b0;
      out_hash_q  <= '0;
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
      err_q       <= 1'b0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      data_q      <= data_d;
      sample_q    <= sample_d;
      value_q     <= value_d;
      out_valid_q <= out_valid_d;
      out_hash_q  <= out_hash_d;
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
      err_q       <= err_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_hash  = out_hash_q;
  assign sample        = sample_q;
  assign value         = value_q;
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
  assign bus.out_err   = out_err_q;
`else
  assign bus.out_err   = 1'b0;
`endif

endmodule
